icache_fill: RTL
================

ICACHE_FILL -- requirements
Module: icache_fill

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8, number of direct-mapped lines; power of two, minimum 2.
REQ-002 SHALL fix the line geometry at 4 beats x 64 bits (32 bytes per line); this is not parameterised.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-low, clock is clk.
REQ-005 SHALL have port ireq_valid, input, 1, instruction fetch request, held stable until iresp_data_ok.
REQ-006 SHALL have port ireq_addr, input, 64, fetch byte address, 4-byte aligned.
REQ-007 SHALL have port iresp_data_ok, output, 1, single-cycle completion pulse.
REQ-008 SHALL have port iresp_data, output, 32, instruction word, valid only with iresp_data_ok.
REQ-009 SHALL have port flush, input, 1, single-cycle invalidate-all pulse (fence.i).
REQ-010 SHALL have port creq, output, cbus_req_t, request to the downstream cbus arbiter input.
REQ-011 SHALL have port cresp, input, cbus_resp_t, response from that arbiter input.

Function
REQ-012 SHALL decode addresses as: offset = addr[4:0], index = addr[5 +: log2(NUM_LINES)], tag = remaining upper bits of addr[63:0].
REQ-013 SHALL hold per line: valid bit, tag, and 4 x 64-bit data words.
REQ-014 SHALL treat addr[31]==0 as uncached (MMIO) and addr[31]==1 as cacheable.
REQ-015 SHALL implement states IDLE, FILL, UNCACHED, DONE.
REQ-016 IDLE, cacheable hit (valid and tag match) -> SHALL assert iresp_data_ok in the same cycle; iresp_data = word addr[2] of beat addr[4:3]; state stays IDLE.
REQ-017 IDLE, cacheable miss -> SHALL go to FILL next cycle; iresp_data_ok stays 0.
REQ-018 FILL: creq.valid=1, is_write=0, addr = ireq_addr with bits [4:0] cleared, size = 8 bytes, len = 4 beats, burst = INCR, strobe = 0.
REQ-019 FILL: each cycle with cresp.ready=1 SHALL write cresp.data into the beat selected by a 2-bit beat counter (start 0), then increment the counter.
REQ-020 FILL: a cresp.ready beat with cresp.last=1 SHALL write tag, set valid (unless a flush is pending, REQ-026), and go to DONE.
REQ-021 IDLE, uncached request -> SHALL go to UNCACHED, never allocating a line.
REQ-022 UNCACHED: creq.valid=1, is_write=0, addr = ireq_addr with bits [2:0] cleared, size = 8 bytes, len = 1 beat, burst = FIXED, strobe = 0.
REQ-023 UNCACHED: on cresp.ready with cresp.last SHALL latch the selected 32-bit half (addr[2]) and go to DONE.
REQ-024 DONE: SHALL assert iresp_data_ok for exactly one cycle with the fetched word (from the filled line or the uncached latch), then return to IDLE; creq.valid=0 in DONE.
REQ-025 creq SHALL be all-zero in IDLE and DONE; creq fields SHALL be stable for the whole FILL/UNCACHED transaction.
REQ-026 flush in IDLE SHALL clear all valid bits at the next edge; a request in the same cycle SHALL see the pre-flush state for its hit check.
REQ-027 flush in FILL/UNCACHED/DONE SHALL set a pending bit; the in-flight fill SHALL complete and return data but leave its line invalid; all valid bits clear on entering IDLE; pending cleared then.
REQ-028 SHALL ignore cresp when creq.valid=0.
REQ-029 Beat counter SHALL wrap 3->0; a last earlier than beat 3 is an error and SHALL still end FILL (line marked valid).

Reset
REQ-030 With reset=0 at a clock edge: state = IDLE, all valid bits = 0, beat counter = 0, flush pending = 0, iresp_data_ok = 0, iresp_data = 0, creq = 0.
REQ-031 Reset mid-FILL SHALL abandon the transaction, with creq = 0 from the next cycle and no line validated.
REQ-032 Data and tag arrays need not be reset.

Verification
REQ-033 Cold miss at 0x8000_0040, 4 beats of data D0..D3 with ready on consecutive cycles -> creq addr 0x8000_0040, len 4; data_ok pulses one cycle after the last beat with D0[31:0].
REQ-034 After REQ-033, fetch 0x8000_005C -> same-cycle data_ok, data = D3[63:32], creq stays 0.
REQ-035 Fetch 0x1000_0004 (uncached), response 0xAAAA_BBBB_CCCC_DDDD -> single-beat creq at 0x1000_0000; data = 0xAAAA_BBBB; a repeat fetch issues the bus request again.
REQ-036 flush asserted during beat 2 of a fill -> fetch completes with correct data; a refetch of the same address misses and refills.
REQ-037 Conflict: fill 0x8000_0000, then 0x8000_0100 (same index when NUM_LINES=8) -> the second access evicts; refetching 0x8000_0000 misses.
REQ-038 reset=0 for one cycle during FILL beat 1 -> creq = 0 next cycle, no data_ok; a subsequent fetch to the same address misses.

Source files
------------

// File: rtl/icache_fill.sv
// Direct-mapped instruction cache with 4x64-bit line fill and uncached single-beat
// fetch over the cbus arbiter port; bus types live in the package below.
package icache_fill_pkg;
    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1
    } cbus_burst_t;

    // size is log2(bytes per beat); len is the number of beats in the burst
    localparam logic [2:0] CBUS_SIZE_8B = 3'd3;
    localparam logic [7:0] CBUS_LEN_1   = 8'd1;
    localparam logic [7:0] CBUS_LEN_4   = 8'd4;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  len;
        cbus_burst_t burst;
        logic [7:0]  strobe;
        logic [63:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module icache_fill
    import icache_fill_pkg::*;
#(
    parameter int NUM_LINES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        flush,
    output cbus_req_t   creq,
    input  cbus_resp_t  cresp
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 64 - 5 - IDX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILL     = 2'd1,
        UNCACHED = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [63:0]          data_q [NUM_LINES][4];
    logic [1:0]           beat_q;
    logic                 pending_q;
    logic                 done_unc_q;
    logic [31:0]          unc_q;

    logic                 fill_we, fill_done, unc_done;

    wire [IDX_W-1:0] idx       = ireq_addr[5 +: IDX_W];
    wire [TAG_W-1:0] tag       = ireq_addr[63 -: TAG_W];
    wire [1:0]       beat_sel  = ireq_addr[4:3];
    wire             half_sel  = ireq_addr[2];
    wire             cacheable = ireq_addr[31];
    wire             hit       = valid_q[idx] && (tag_q[idx] == tag);
    wire             unused_ok = &{1'b0, ireq_addr[1:0]};

    function automatic logic [31:0] pick_half(input logic [63:0] w, input logic hi);
        return hi ? w[63:32] : w[31:0];
    endfunction

    always_comb begin
        state_d       = state_q;
        creq          = '0;
        iresp_data_ok = 1'b0;
        iresp_data    = '0;
        fill_we       = 1'b0;
        fill_done     = 1'b0;
        unc_done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ireq_valid) begin
                    if (!cacheable) begin
                        state_d = UNCACHED;
                    end else if (hit) begin
                        iresp_data_ok = 1'b1;
                        iresp_data    = pick_half(data_q[idx][beat_sel], half_sel);
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                creq.valid = 1'b1;
                creq.addr  = {ireq_addr[63:5], 5'b0};
                creq.size  = CBUS_SIZE_8B;
                creq.len   = CBUS_LEN_4;
                creq.burst = BURST_INCR;
                if (cresp.ready) begin
                    fill_we = 1'b1;
                    if (cresp.last) begin
                        fill_done = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            UNCACHED: begin
                creq.valid = 1'b1;
                creq.addr  = {ireq_addr[63:3], 3'b0};
                creq.size  = CBUS_SIZE_8B;
                creq.len   = CBUS_LEN_1;
                creq.burst = BURST_FIXED;
                if (cresp.ready && cresp.last) begin
                    unc_done = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                iresp_data_ok = 1'b1;
                iresp_data    = done_unc_q ? unc_q
                                           : pick_half(data_q[idx][beat_sel], half_sel);
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // While reset is low nothing leaves the block and nothing is captured
        if (!reset) begin
            state_d       = IDLE;
            creq          = '0;
            iresp_data_ok = 1'b0;
            iresp_data    = '0;
            fill_we       = 1'b0;
            fill_done     = 1'b0;
            unc_done      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            beat_q     <= 2'd0;
            pending_q  <= 1'b0;
            done_unc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (flush) valid_q <= '0;
                    // The line is overwritten beat by beat, so drop it before the first beat
                    if (state_d == FILL) valid_q[idx] <= 1'b0;
                    beat_q     <= 2'd0;
                    done_unc_q <= (state_d == UNCACHED);
                end
                FILL: begin
                    if (flush) pending_q <= 1'b1;
                    if (fill_we) beat_q <= beat_q + 2'd1;
                    if (fill_done) begin
                        beat_q       <= 2'd0;
                        valid_q[idx] <= !(pending_q || flush);
                    end
                end
                UNCACHED: begin
                    if (flush) pending_q <= 1'b1;
                end
                DONE: begin
                    if (pending_q || flush) valid_q <= '0;
                    pending_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) data_q[idx][beat_q] <= cresp.data;
        if (fill_done) tag_q[idx] <= tag;
        if (unc_done) unc_q <= pick_half(cresp.data, half_sel);
    end
endmodule
